axi_lite_cmd_master: RTL

- Single-outstanding AXI4-Lite initiator that turns a simple command/response stream into register transactions on the memory-test register slave.
- Driven by the host bridge (UART/JTAG command decoder); sits on the axi_aclk domain.
- Issues one read or one write at a time, returns the read data and response code, and bounds every transaction with a timeout.

---
 rtl/axi_lite_pkg.sv | 17 +
 rtl/axi_lite_timeout_cnt.sv | 39 +++
 rtl/axi_lite_cmd_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite command master.
// Contents: AXI response codes and the master FSM state type.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WB,
    RD,
    RR,
    RSP
  } state_t;

endpackage

// File: rtl/axi_lite_timeout_cnt.sv
// Per-transaction cycle budget for the AXI4-Lite command master.
// Ports:
//   axi_aclk, axi_resetn : clock, asynchronous active-low reset
//   clear                : restart the budget (command accepted)
//   enable               : an AXI transaction is in flight this cycle
//   expired              : this in-flight cycle is the last one allowed
// TIMEOUT_CYCLES = 0 disables expiry.
module axi_lite_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic axi_aclk,
  input  logic axi_resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  // count holds the number of in-flight cycles already completed, so the
  // current cycle is number count+1; expiry is flagged on cycle
  // TIMEOUT_CYCLES itself, before that cycle's handshakes take effect.
  logic [CW-1:0] count;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count >= LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a command/response stream.
// Ports:
//   axi_aclk, axi_resetn        : clock, asynchronous active-low reset
//   cmd_*                       : command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                       : response out (valid/ready, rdata, resp, timeout, write)
//   axi_aw*/axi_w*/axi_b*       : AXI4-Lite write channels
//   axi_ar*/axi_r*              : AXI4-Lite read channels
// One read or write at a time; every transaction is bounded by TIMEOUT_CYCLES
// (0 = unbounded). A timeout aborts the AXI transaction and reports SLVERR.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    rsp_write,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wvalid,
  output logic                    axi_wlast,
  input  logic                    axi_wready,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready
);

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    write_q;
  logic                    aw_done, w_done;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;
  logic                    timeout_q;

  logic accept, aw_hs, w_hs, b_hs, r_hs, abort;
  logic timer_en, expired;

  // Single-beat reads: RLAST carries no information here.
  logic unused_rlast;
  assign unused_rlast = axi_rlast;

  axi_lite_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .axi_aclk  (axi_aclk),
    .axi_resetn(axi_resetn),
    .clear     (accept),
    .enable    (timer_en),
    .expired   (expired)
  );

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // On expiry every AXI valid/ready is withheld in that cycle, so a slave
  // handshake offered on the expiry cycle can never complete.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    b_hs        = 1'b0;
    r_hs        = 1'b0;
    abort       = 1'b0;
    timer_en    = 1'b0;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        // Gated by reset so the port reads 0 while reset is held.
        cmd_ready = axi_resetn;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = cmd_write ? WR : RD;
        end
      end
      WR: begin
        timer_en = 1'b1;
        if (expired) begin
          abort      = 1'b1;
          state_next = RSP;
        end else begin
          axi_awvalid = !aw_done;
          axi_wvalid  = !w_done;
          aw_hs       = axi_awvalid && axi_awready;
          w_hs        = axi_wvalid && axi_wready;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state_next = WB;
          end
        end
      end
      WB: begin
        timer_en = 1'b1;
        if (expired) begin
          abort      = 1'b1;
          state_next = RSP;
        end else begin
          axi_bready = 1'b1;
          b_hs       = axi_bvalid;
          if (b_hs) state_next = RSP;
        end
      end
      RD: begin
        timer_en = 1'b1;
        if (expired) begin
          abort      = 1'b1;
          state_next = RSP;
        end else begin
          axi_arvalid = 1'b1;
          if (axi_arready) state_next = RR;
        end
      end
      RR: begin
        timer_en = 1'b1;
        if (expired) begin
          abort      = 1'b1;
          state_next = RSP;
        end else begin
          axi_rready = 1'b1;
          r_hs       = axi_rvalid;
          if (r_hs) state_next = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        wstrb_q   <= cmd_wstrb;
        write_q   <= cmd_write;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        rdata_q   <= '0;
        resp_q    <= RESP_OKAY;
        timeout_q <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (b_hs) resp_q <= axi_bresp;
      if (r_hs) begin
        rdata_q <= axi_rdata;
        resp_q  <= axi_rresp;
      end
      if (abort) begin
        timeout_q <= 1'b1;
        resp_q    <= RESP_SLVERR;
        rdata_q   <= '0;
      end
    end
  end

  assign axi_awaddr  = addr_q;
  assign axi_araddr  = addr_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = axi_wvalid;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;
  assign rsp_write   = write_q;

endmodule
